// File: rtl/video_timing_ctrl.sv
// Pixel-clock video timing generator with HPD-gated start-up and an upstream
// valid/ready pixel pull. Produces registered VDE/HSYNC/VSYNC/RGB for the TMDS encoders.
module video_timing_ctrl #(
    parameter int          H_ACTIVE  = 640,
    parameter int          H_FP      = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BP      = 48,
    parameter int          V_ACTIVE  = 480,
    parameter int          V_FP      = 10,
    parameter int          V_SYNC    = 2,
    parameter int          V_BP      = 33,
    parameter bit          SYNC_POL  = 1'b0,
    parameter int          HPD_DEB   = 1024,
    parameter logic [23:0] BLANK_RGB = 24'h0
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iEnable,
    input  logic        iHdmiHpd,
    input  logic [23:0] iPixel,
    input  logic        iPixelValid,
    output logic        oPixelReady,
    input  logic        iUnderflowClr,
    output logic [23:0] oVRGB,
    output logic        oVDE,
    output logic        oHSYNC,
    output logic        oVSYNC,
    output logic        oFrameStart,
    output logic        oUnderflow,
    output logic [1:0]  oState
);

    // state    | meaning
    // IDLE     | counters held at 0, waiting for iEnable & synced HPD
    // DEBOUNCE | HPD and iEnable must stay high for HPD_DEB clocks
    // RUN      | free-running raster, frame starts reported
    // STOPPING | iEnable dropped, current frame finishes then IDLE
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        RUN      = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam int HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int DEB_W    = (HPD_DEB > 1) ? $clog2(HPD_DEB) : 1;

    localparam logic [11:0]      HT_M1    = 12'(HT - 1);
    localparam logic [11:0]      VT_M1    = 12'(VT - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(HPD_DEB - 1);

    state_t             state;
    logic               hpdMeta;
    logic               hpdS;
    logic [11:0]        hcnt;
    logic [11:0]        vcnt;
    logic [DEB_W-1:0]   debCnt;

    logic        running;
    logic        active;
    logic        hEnd;
    logic        vEnd;
    logic        frameEnd;
    logic        hpdLost;
    logic        hsyncOn;
    logic        vsyncOn;
    logic [11:0] hNext;
    logic [11:0] vNext;

    assign running     = (state == RUN) || (state == STOPPING);
    assign active      = running && (int'(hcnt) < H_ACTIVE) && (int'(vcnt) < V_ACTIVE);
    assign oPixelReady = active;
    assign oState      = state;

    assign hEnd     = (hcnt == HT_M1);
    assign vEnd     = (vcnt == VT_M1);
    assign frameEnd = hEnd && vEnd;
    assign hNext    = hEnd ? 12'd0 : hcnt + 12'd1;
    assign vNext    = hEnd ? (vEnd ? 12'd0 : vcnt + 12'd1) : vcnt;
    assign hpdLost  = running && !hpdS;

    assign hsyncOn = (int'(hcnt) >= HS_START) && (int'(hcnt) < HS_END);
    assign vsyncOn = (int'(vcnt) >= VS_START) && (int'(vcnt) < VS_END);

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state       <= IDLE;
            hpdMeta     <= 1'b0;
            hpdS        <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            debCnt      <= '0;
            oVRGB       <= 24'h0;
            oVDE        <= 1'b0;
            oHSYNC      <= ~SYNC_POL;
            oVSYNC      <= ~SYNC_POL;
            oFrameStart <= 1'b0;
            oUnderflow  <= 1'b0;
        end else begin
            hpdMeta <= iHdmiHpd;
            hpdS    <= hpdMeta;

            // set dominates clear
            if (active && !iPixelValid) begin
                oUnderflow <= 1'b1;
            end else if (iUnderflowClr) begin
                oUnderflow <= 1'b0;
            end

            if (hpdLost) begin
                oVRGB       <= 24'h0;
                oVDE        <= 1'b0;
                oHSYNC      <= ~SYNC_POL;
                oVSYNC      <= ~SYNC_POL;
                oFrameStart <= 1'b0;
            end else begin
                oVDE        <= active;
                oVRGB       <= active ? (iPixelValid ? iPixel : BLANK_RGB) : 24'h0;
                oHSYNC      <= hsyncOn ? SYNC_POL : ~SYNC_POL;
                oVSYNC      <= vsyncOn ? SYNC_POL : ~SYNC_POL;
                oFrameStart <= (state == RUN) && iEnable && (hcnt == 12'd0) && (vcnt == 12'd0);
            end

            case (state)
                IDLE: begin
                    hcnt <= '0;
                    vcnt <= '0;
                    if (iEnable && hpdS) begin
                        state  <= DEBOUNCE;
                        debCnt <= '0;
                    end
                end
                DEBOUNCE: begin
                    if (!(iEnable && hpdS)) begin
                        state <= IDLE;
                    end else if (debCnt == DEB_LAST) begin
                        state <= RUN;
                        hcnt  <= '0;
                        vcnt  <= '0;
                    end else begin
                        debCnt <= debCnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!hpdS) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        vcnt  <= '0;
                    end else begin
                        hcnt <= hNext;
                        vcnt <= vNext;
                        if (!iEnable) begin
                            state <= STOPPING;
                        end
                    end
                end
                STOPPING: begin
                    if (!hpdS) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        vcnt  <= '0;
                    end else if (iEnable) begin
                        // resume without disturbing the raster
                        state <= RUN;
                        hcnt  <= hNext;
                        vcnt  <= vNext;
                    end else if (frameEnd) begin
                        state <= IDLE;
                        hcnt  <= '0;
                        vcnt  <= '0;
                    end else begin
                        hcnt <= hNext;
                        vcnt <= vNext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Bench for video_timing_ctrl on a small 8x6 raster: raster-index reference model
// checked every cycle, plus directed sequences with hand-derived counts.
module tb_video_timing_ctrl;

    localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
    localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
    localparam int DEB = 8;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam logic [23:0] BLANK = 24'h5A5A5A;

    logic        iClk = 1'b0;
    logic        iRst = 1'b0;
    logic        iEnable = 1'b0;
    logic        iHdmiHpd = 1'b0;
    logic [23:0] iPixel = 24'h0;
    logic        iPixelValid = 1'b0;
    logic        iUnderflowClr = 1'b0;
    logic        oPixelReady;
    logic [23:0] oVRGB;
    logic        oVDE, oHSYNC, oVSYNC, oFrameStart, oUnderflow;
    logic [1:0]  oState;

    int nTests = 0;
    int nFail  = 0;
    bit chkEn  = 1'b0;

    video_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b0), .HPD_DEB(DEB), .BLANK_RGB(BLANK)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iHdmiHpd(iHdmiHpd),
        .iPixel(iPixel), .iPixelValid(iPixelValid), .oPixelReady(oPixelReady),
        .iUnderflowClr(iUnderflowClr), .oVRGB(oVRGB), .oVDE(oVDE),
        .oHSYNC(oHSYNC), .oVSYNC(oVSYNC), .oFrameStart(oFrameStart),
        .oUnderflow(oUnderflow), .oState(oState)
    );

    initial forever #5 iClk = ~iClk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: raster position as one linear index, sync polarity active-low.
    int          mState, pos, deb, mh, mv;
    bit          mS1, mS2, mAct;
    logic        eVDE, eHS, eVS, eFS, eUF;
    logic [23:0] eRGB;

    function automatic bit modelReady();
        return (mState >= 2) && ((pos % HT) < HA) && ((pos / HT) < VA);
    endfunction

    always @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            mState = 0; pos = 0; deb = 0; mS1 = 0; mS2 = 0;
            eVDE = 0; eRGB = 0; eHS = 1; eVS = 1; eFS = 0; eUF = 0;
        end else begin
            mh   = pos % HT;
            mv   = pos / HT;
            mAct = modelReady();
            if (mAct && !iPixelValid) eUF = 1;
            else if (iUnderflowClr)   eUF = 0;
            if (mState >= 2 && !mS2) begin
                eVDE = 0; eRGB = 0; eHS = 1; eVS = 1; eFS = 0;
                mState = 0; pos = 0;
            end else begin
                eVDE = mAct;
                eRGB = mAct ? (iPixelValid ? iPixel : BLANK) : 24'h0;
                eHS  = !(mh >= HA + HF && mh < HA + HF + HSW);
                eVS  = !(mv >= VA + VF && mv < VA + VF + VSW);
                eFS  = (mState == 2) && (pos == 0) && iEnable;
                case (mState)
                    0: begin
                        pos = 0;
                        if (iEnable && mS2) begin mState = 1; deb = 0; end
                    end
                    1: begin
                        if (!(iEnable && mS2)) mState = 0;
                        else if (deb == DEB - 1) begin mState = 2; pos = 0; end
                        else deb++;
                    end
                    2: begin
                        pos = (pos + 1) % FRAME;
                        if (!iEnable) mState = 3;
                    end
                    default: begin
                        if (iEnable) begin mState = 2; pos = (pos + 1) % FRAME; end
                        else if (pos == FRAME - 1) begin mState = 0; pos = 0; end
                        else pos++;
                    end
                endcase
            end
            mS2 = mS1;
            mS1 = iHdmiHpd;
        end
    end

    always @(negedge iClk) begin
        if (chkEn) begin
            check("state", {30'd0, oState}, mState);
            check("ready", oPixelReady, modelReady());
            check("vde", oVDE, eVDE);
            check("rgb", oVRGB, eRGB);
            check("hsync", oHSYNC, eHS);
            check("vsync", oVSYNC, eVS);
            check("framestart", oFrameStart, eFS);
            check("underflow", oUnderflow, eUF);
        end
    end

    int xferCnt, vdeCnt, hsCnt, vsCnt, fsCnt;

    task automatic clrCounts();
        xferCnt = 0; vdeCnt = 0; hsCnt = 0; vsCnt = 0; fsCnt = 0;
    endtask

    task automatic tick();
        if (oPixelReady && iPixelValid) xferCnt++;
        @(posedge iClk);
        #1;
        if (oVDE)        vdeCnt++;
        if (!oHSYNC)     hsCnt++;
        if (!oVSYNC)     vsCnt++;
        if (oFrameStart) fsCnt++;
        iPixel = $urandom;
    endtask

    task automatic waitState(input int st, input int maxT, output int n);
        n = 0;
        while (oState !== 2'(st) && n < maxT) begin
            tick();
            n++;
        end
    endtask

    task automatic waitFs(input int maxT, output int n);
        n = 0;
        while (oFrameStart !== 1'b1 && n < maxT) begin
            tick();
            n++;
        end
    endtask

    task automatic checkResetLevels(input string tag);
        check({tag, "_state"}, {30'd0, oState}, 0);
        check({tag, "_hsync"}, oHSYNC, 1);
        check({tag, "_vsync"}, oVSYNC, 1);
        check({tag, "_vde"}, oVDE, 0);
        check({tag, "_ready"}, oPixelReady, 0);
        check({tag, "_fs"}, oFrameStart, 0);
        check({tag, "_rgb"}, oVRGB, 0);
    endtask

    initial begin
        int n;
        clrCounts();
        repeat (3) tick();
        checkResetLevels("rst");
        check("rst_uf", oUnderflow, 0);
        iRst = 1'b1;
        chkEn = 1'b1;
        repeat (4) tick();

        // start-up: HPD and enable together, 2 sync + 1 entry + 8 debounce edges
        iHdmiHpd = 1'b1; iEnable = 1'b1; iPixelValid = 1'b1;
        waitState(2, 60, n);
        check("run_latency", n, 11);
        waitFs(100, n);
        check("fs_after_run", n, 1);

        clrCounts();
        repeat (FRAME) tick();
        check("fs_period", oFrameStart, 1);
        check("fs_per_frame", fsCnt, 1);
        check("vde_per_frame", vdeCnt, 12);
        check("xfer_per_frame", xferCnt, 12);
        check("hsync_low", hsCnt, 12);
        check("vsync_low", vsCnt, 8);

        // underflow on the third active pixel of the frame
        clrCounts();
        tick();
        iPixelValid = 1'b0;
        tick();
        check("uf_vde", oVDE, 1);
        check("uf_blank", oVRGB, BLANK);
        check("uf_set", oUnderflow, 1);
        iPixelValid = 1'b1;
        repeat (FRAME - 2) tick();
        check("uf_xfers", xferCnt, 11);
        check("uf_sticky", oUnderflow, 1);
        iUnderflowClr = 1'b1;
        tick();
        iUnderflowClr = 1'b0;
        check("uf_clear", oUnderflow, 0);

        // randomized traffic including enable glitches
        for (int i = 0; i < 400; i++) begin
            iPixelValid   = ($urandom_range(3) != 0);
            iUnderflowClr = ($urandom_range(7) == 0);
            if ($urandom_range(39) == 0) iEnable = ~iEnable;
            tick();
        end
        iPixelValid = 1'b1; iUnderflowClr = 1'b0; iEnable = 1'b1;
        waitState(2, 100, n);
        check("rand_recover", {30'd0, oState}, 2);
        waitFs(200, n);
        check("rand_fs", oFrameStart, 1);

        // stop at pixel (1,1): 38 more edges to the end of the frame
        repeat (HT) tick();
        iEnable = 1'b0;
        tick();
        check("stop_state", {30'd0, oState}, 3);
        clrCounts();
        waitState(0, 200, n);
        check("stop_len", n, 38);
        check("stop_no_fs", fsCnt, 0);
        clrCounts();
        repeat (60) tick();
        check("idle_no_fs", fsCnt, 0);
        check("idle_no_xfer", xferCnt, 0);
        check("idle_state", {30'd0, oState}, 0);

        // HPD glitch during debounce restarts it
        iEnable = 1'b1;
        tick();
        check("deb_state", {30'd0, oState}, 1);
        repeat (3) tick();
        iHdmiHpd = 1'b0;
        repeat (5) tick();
        check("deb_abort", {30'd0, oState}, 0);
        iHdmiHpd = 1'b1;
        waitFs(100, n);
        check("deb_restart", n, 12);

        // HPD loss in RUN: 2 sync edges plus 1
        repeat (12) tick();
        iHdmiHpd = 1'b0;
        waitState(0, 20, n);
        check("hpd_loss_latency", n, 3);
        checkResetLevels("hpd_loss");

        // asynchronous reset in the middle of active video
        iHdmiHpd = 1'b1;
        waitState(2, 60, n);
        check("rerun", {30'd0, oState}, 2);
        n = 0;
        while (oVDE !== 1'b1 && n < 60) begin tick(); n++; end
        check("mid_vde", oVDE, 1);
        #2;
        iRst = 1'b0;
        #1;
        checkResetLevels("async_rst");
        repeat (3) tick();
        iRst = 1'b1;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
